receive_pixel: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx.sv | 147 ++++++++++++++
 rtl/receive_pixel.sv | 141 ++++++++++++++
 tb/tb_receive_pixel.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state types for the pixel-link UART receive path.
package uart_pkg;

    // clk cycles per bit for 115200 baud from a 100 MHz system clock
    localparam int CLKS_PER_BIT_115200 = 868;

    // data bits per UART frame
    localparam int BITS_N = 8;

    // parity selectors: the value the XOR of data and parity bit must equal
    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

    // pairing FSM states
    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        WAIT_LOW  = 2'd1,
        LOAD      = 2'd2
    } pixel_rx_state_t;

    // byte receiver states
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampling, parity check.
// Frame: start, BITS_N data bits LSB first, parity, stop.
// Build option RECEIVE_PIXEL_PARITY_EN: when defined parity_err_o reports
// parity mismatches; otherwise the parity bit is sampled but ignored and
// parity_err_o is always 0.
module uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_115200,
    parameter int BITS_N       = uart_pkg::BITS_N,
    parameter bit PARITY_TYPE  = uart_pkg::PARITY_EVEN
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    output logic [BITS_N-1:0] byte_data_o,
    output logic              byte_valid_o,
    output logic              parity_err_o
);

`ifdef RECEIVE_PIXEL_PARITY_EN
    localparam bit PARITY_CHK_EN = 1'b1;
`else
    localparam bit PARITY_CHK_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_N - 1);

    uart_pkg::uart_rx_state_t state_q, state_d;
    logic [1:0]        sync_q;
    logic              rx_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BITS_N-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              byte_valid_q, byte_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              rx;

    assign rx = sync_q[1];

    // Synchronise the asynchronous line and keep one delayed copy for edge detect
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            rx_prev_q <= rx;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= uart_pkg::RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            byte_valid_q <= byte_valid_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Bit timing: confirm start at half a bit, then sample every full bit period
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        parity_err_d = 1'b0;
        case (state_q)
            uart_pkg::RX_IDLE: begin
                if (!rx && rx_prev_q) begin
                    state_d = uart_pkg::RX_START;
                    cnt_d   = '0;
                end
            end
            uart_pkg::RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? uart_pkg::RX_IDLE : uart_pkg::RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            uart_pkg::RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[BITS_N-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = uart_pkg::RX_PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            uart_pkg::RX_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rx;
                    state_d = uart_pkg::RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            uart_pkg::RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = uart_pkg::RX_IDLE;
                    // a low stop bit drops the byte silently
                    if (rx) begin
                        byte_valid_d = 1'b1;
                        parity_err_d = PARITY_CHK_EN &&
                                       ((^shift_q ^ par_q) != PARITY_TYPE);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = uart_pkg::RX_IDLE;
            end
        endcase
    end

    assign byte_data_o  = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign parity_err_o = parity_err_q;

endmodule

// File: rtl/receive_pixel.sv
// Pixel link receiver: pairs UART bytes (high = pixel[11:4], low = {0, pixel[3:0]})
// into 12-bit pixels and presents them on a one-deep valid/ready register.
// Build option RECEIVE_PIXEL_PARITY_EN: parity-failed bytes are discarded with
// a framing_err pulse and the pairing restarts at WAIT_HIGH.
module receive_pixel
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int TIMEOUT_CLKS = 16 * CLKS_PER_BIT * 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_in,
    input  logic        ready_in,
    output logic [11:0] pixel_out,
    output logic        valid_out,
    output logic        framing_err,
    output logic        overrun
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       parity_err;

    pixel_rx_state_t state_q, state_d;
    logic [7:0]       hi_q, hi_d;
    logic [11:0]      pix_q, pix_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [11:0]      pixel_q, pixel_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .BITS_N       (BITS_N),
        .PARITY_TYPE  (PARITY_EVEN)
    ) u_rx (
        .clk_i        (clk),
        .rst_ni       (rst),
        .rx_i         (uart_in),
        .byte_data_o  (byte_data),
        .byte_valid_o (byte_valid),
        .parity_err_o (parity_err)
    );

    // Pairing FSM, timeout counter and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_HIGH;
            hi_q    <= '0;
            pix_q   <= '0;
            tmo_q   <= '0;
            pixel_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            pix_q   <= pix_d;
            tmo_q   <= tmo_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: byte pairing, timeout, load/overrun and handshake release
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        pix_d   = pix_q;
        tmo_d   = tmo_q;
        pixel_d = pixel_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end

        case (state_q)
            WAIT_HIGH: begin
                if (byte_valid) begin
                    if (parity_err) begin
                        ferr_d = 1'b1;
                    end else begin
                        hi_d    = byte_data;
                        tmo_d   = '0;
                        state_d = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: begin
                // an arriving byte takes priority over a same-cycle timeout
                if (byte_valid) begin
                    if (parity_err) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end else if (byte_data[7:4] == 4'd0) begin
                        pix_d   = {hi_q, byte_data[3:0]};
                        state_d = LOAD;
                    end else begin
                        ferr_d = 1'b1;
                        hi_d   = byte_data;
                        tmo_d  = '0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_HIGH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            LOAD: begin
                if (!valid_q || ready_in) begin
                    pixel_d = pix_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = WAIT_HIGH;
            end
            default: begin
                state_d = WAIT_HIGH;
            end
        endcase
    end

    assign pixel_out   = pixel_q;
    assign valid_out   = valid_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_receive_pixel.sv
// Scoreboard bench for receive_pixel with CLKS_PER_BIT = 4.
module tb_receive_pixel;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic        uart_in;
    logic        ready_in;
    logic [11:0] pixel_out;
    logic        valid_out;
    logic        framing_err;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q[$];
    int  fe_cnt = 0;
    int  ov_cnt = 0;
    int  cyc = 0;
    int  last_bv = -100;
    logic valid_prev = 1'b0;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;

    receive_pixel #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_in     (uart_in),
        .ready_in    (ready_in),
        .pixel_out   (pixel_out),
        .valid_out   (valid_out),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // monitor: pops the scoreboard on each accepted pixel, tracks pulses
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            valid_prev = 1'b0;
            fe_prev    = 1'b0;
            ov_prev    = 1'b0;
        end else begin
            if (dut.byte_valid) last_bv = cyc;
            if (valid_out && !valid_prev) begin
                check("valid_latency", cyc - last_bv, 2);
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got 0x%0h expected none", pixel_out);
                end else begin
                    check("pixel_out", int'(pixel_out), int'(exp_q.pop_front()));
                end
            end
            if (framing_err) begin
                fe_cnt++;
                if (fe_prev) check("framing_err_width", 2, 1);
            end
            if (overrun) begin
                ov_cnt++;
                if (ov_prev) check("overrun_width", 2, 1);
            end
            valid_prev = valid_out;
            fe_prev    = framing_err;
            ov_prev    = overrun;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // send one frame; bad_par flips the even-parity bit
    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic [10:0] fr;
        fr = {1'b1, (^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            uart_in = fr[i];
            tick(CPB);
        end
        uart_in = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        uart_in  = 1'b1;
        ready_in = 1'b1;
        #23;
        check("rst_pixel_out",   int'(pixel_out),   0);
        check("rst_valid_out",   int'(valid_out),   0);
        check("rst_framing_err", int'(framing_err), 0);
        check("rst_overrun",     int'(overrun),     0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick(5);

        // basic pair
        exp_q.push_back(12'hABC);
        send_byte(8'hAB, 1'b0);
        send_byte(8'h0C, 1'b0);
        drain("t1_drain");
        tick(2);
        check("t1_valid_one_cycle", int'(valid_out), 0);
        check("t1_fe", fe_cnt, 0);
        check("t1_ov", ov_cnt, 0);

        // non-low byte while waiting for low byte
        exp_q.push_back(12'h345);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h05, 1'b0);
        drain("t2_drain");
        check("t2_fe", fe_cnt, 1);

        // timeout back to WAIT_HIGH
        send_byte(8'hFF, 1'b0);
        tick(800);
        check("t3_timeout_fe", fe_cnt, 2);
        exp_q.push_back(12'h000);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        drain("t3_drain");
        check("t3_fe_after", fe_cnt, 2);

        // backpressure and overrun
        ready_in = 1'b0;
        exp_q.push_back(12'h111);
        send_byte(8'h11, 1'b0);
        send_byte(8'h01, 1'b0);
        tick(4);
        check("t4_hold_valid", int'(valid_out), 1);
        check("t4_hold_pixel", int'(pixel_out), 12'h111);
        send_byte(8'h22, 1'b0);
        send_byte(8'h02, 1'b0);
        tick(4);
        check("t4_overrun", ov_cnt, 1);
        check("t4_keep_pixel", int'(pixel_out), 12'h111);
        ready_in = 1'b1;
        tick(1);
        check("t4_valid_drop", int'(valid_out), 0);
        check("t4_queue", exp_q.size(), 0);

        // parity-flipped byte: one framing_err in either build, same pixel
        exp_q.push_back(12'h5A6);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h06, 1'b0);
        drain("t5_drain");
        check("t5_fe", fe_cnt, 3);
        check("t5_ov", ov_cnt, 1);

        // reset during the stop bit of a low byte
        send_byte(8'h77, 1'b0);
        begin
            logic [10:0] fr;
            fr = {1'b1, ^8'h07, 8'h07, 1'b0};
            for (int i = 0; i < 10; i++) begin
                uart_in = fr[i];
                tick(CPB);
            end
            uart_in = 1'b1;
            tick(1);
        end
        rst = 1'b0;
        #1;
        check("t6_pixel_out", int'(pixel_out),   0);
        check("t6_valid_out", int'(valid_out),   0);
        check("t6_fe",        int'(framing_err), 0);
        check("t6_ov",        int'(overrun),     0);
        tick(3);
        rst = 1'b1;
        tick(100);
        check("t6_no_valid", int'(valid_out), 0);
        check("t6_fe_cnt", fe_cnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
